add8_err_monitor: RTL

- Downstream characterisation stage for the 8-bit approximate adders in the library.
- Consumes one operand pair (A, B) and the approximate adder's 9-bit result O per accepted beat.
- Computes the exact sum internally and accumulates the error metrics the library publishes for each circuit: sample count, sum of absolute errors (SAE, for MAE), worst-case error (WCE) and error count (for EP).
- Runs a fixed-length measurement, e.g. an exhaustive 65536-pair sweep, under a start/done handshake.

---
 rtl/add8_err_monitor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/add8_err_monitor.sv
// Error-metric monitor for 8-bit approximate adders: accumulates sample count, SAE, WCE and error count.
// Optional ADD8_ERR_MONITOR_SQERR_EN adds an sse output (sum of squared errors) for MSE reporting.
module add8_err_monitor #(
    parameter int W         = 8,
    parameter int CNT_W     = 17,
    parameter int N_SAMPLES = 65536
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [W:0]             in_o,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W+W:0]       sae,
`ifdef ADD8_ERR_MONITOR_SQERR_EN
    output logic [CNT_W+2*W+1:0]   sse,
`endif
    output logic [W:0]             wce
);

    localparam int SAE_W = CNT_W + W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
`ifdef ADD8_ERR_MONITOR_SQERR_EN
    localparam int SQ_W  = 2 * W + 2;
    localparam int SSE_W = CNT_W + 2 * W + 2;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept;

    // Input capture stage; the accepted beat is registered before the error math.
    logic             cap_v;
    logic [W-1:0]     cap_a;
    logic [W-1:0]     cap_b;
    logic [W:0]       cap_o;

    logic             s1_v;
    logic [W:0]       s1_ad;
    logic             s1_ne;

    logic [W:0]       exact_c;
    logic [W:0]       ad_c;

`ifdef ADD8_ERR_MONITOR_SQERR_EN
    logic [SQ_W-1:0]  ad_ext_c;
    logic [SQ_W-1:0]  s1_sq;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        exact_c = {1'b0, cap_a} + {1'b0, cap_b};
        ad_c    = (exact_c >= cap_o) ? (exact_c - cap_o) : (cap_o - exact_c);
    end

`ifdef ADD8_ERR_MONITOR_SQERR_EN
    assign ad_ext_c = SQ_W'(ad_c);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            acc_cnt    <= '0;
            cap_v      <= 1'b0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_o      <= '0;
            s1_v       <= 1'b0;
            s1_ad      <= '0;
            s1_ne      <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            sae        <= '0;
            wce        <= '0;
`ifdef ADD8_ERR_MONITOR_SQERR_EN
            s1_sq      <= '0;
            sse        <= '0;
`endif
        end else begin
            cap_v <= accept;
            if (accept) begin
                cap_a <= in_a;
                cap_b <= in_b;
                cap_o <= in_o;
            end

            s1_v <= cap_v;
            if (cap_v) begin
                s1_ad <= ad_c;
                s1_ne <= (ad_c != '0);
`ifdef ADD8_ERR_MONITOR_SQERR_EN
                s1_sq <= ad_ext_c * ad_ext_c;
`endif
            end

            if (s1_v) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                err_cnt    <= err_cnt + CNT_W'(s1_ne);
                sae        <= sae + SAE_W'(s1_ad);
                if (s1_ad > wce) wce <= s1_ad;
`ifdef ADD8_ERR_MONITOR_SQERR_EN
                sse        <= sse + SSE_W'(s1_sq);
`endif
            end

            case (state)
                IDLE, DONE: begin
                    // Pipeline is empty here, so the clear never races an S2 update.
                    if (start) begin
                        sample_cnt <= '0;
                        err_cnt    <= '0;
                        sae        <= '0;
                        wce        <= '0;
`ifdef ADD8_ERR_MONITOR_SQERR_EN
                        sse        <= '0;
`endif
                        acc_cnt    <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (acc_cnt == LAST_IDX) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (!cap_v && !s1_v) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
